// File: rtl/record_buffer.sv
// Recorder for free-play notes: stores a take in song-ROM layout (octave/note/length)
// and serves it back through a registered indexed read port. Long idle gaps become rest entries.
module record_buffer #(
   parameter int OCT_W       = 3,
   parameter int NOTE_W      = 3,
   parameter int LEN_W       = 3,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = 6,
   parameter int REST_CYCLES = 50_000_000,
   parameter int GAP_W       = 26,
   parameter logic [LEN_W-1:0] REST_LEN = 3'd2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              start,
   input  logic              stop,
   input  logic              wr_valid,
   input  logic [OCT_W-1:0]  wr_octave,
   input  logic [NOTE_W-1:0] wr_note,
   input  logic [LEN_W-1:0]  wr_length,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [OCT_W-1:0]  rd_octave,
   output logic [NOTE_W-1:0] rd_note,
   output logic [LEN_W-1:0]  rd_length,
   output logic [ADDR_W:0]   track,
   output logic              recording,
   output logic              done,
   output logic              full,
   output logic              busy
);

   localparam int ENT_W = OCT_W + NOTE_W + LEN_W;
   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
   localparam logic [GAP_W-1:0]  REST_X  = GAP_W'(REST_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W:0]     r_track, w_track_nxt;
   logic                r_first_seen, w_first_nxt;
   logic                r_busy, w_busy_nxt;
   logic [GAP_W-1:0]    r_gap, w_gap_nxt;
   logic [ENT_W-1:0]    r_pend, w_pend_nxt;
   logic [ENT_W-1:0]    r_rd;
   logic [ENT_W-1:0]    r_mem [DEPTH];

   logic                w_wr_en;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [ENT_W-1:0]    w_wr_data;
   logic                w_full;
   logic                w_room2;

   assign w_full  = (r_track == DEPTH_X[ADDR_W:0]);
   // A rest only fits when the note that follows it also has a slot.
   assign w_room2 = ({1'b0, r_track} + (ADDR_W+2)'(2)) <= DEPTH_X;

   always_comb begin
      w_state_nxt = r_state;
      w_track_nxt = r_track;
      w_first_nxt = r_first_seen;
      w_busy_nxt  = r_busy;
      w_gap_nxt   = r_gap;
      w_pend_nxt  = r_pend;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_track[ADDR_W-1:0];
      w_wr_data   = r_pend;

      if (!en) begin
         w_state_nxt = S_IDLE;
         w_busy_nxt  = 1'b0;
      end else if (start) begin
         w_state_nxt = S_REC;
         w_track_nxt = '0;
         w_first_nxt = 1'b0;
         w_gap_nxt   = '0;
         w_busy_nxt  = 1'b0;
      end else if (r_state == S_REC) begin
         if (stop)
            w_state_nxt = S_DONE;
         if (r_busy) begin
            // Deferred note lands right after its rest, even on a stop edge.
            w_wr_en     = 1'b1;
            w_wr_data   = r_pend;
            w_track_nxt = r_track + (ADDR_W+1)'(1);
            w_busy_nxt  = 1'b0;
            w_gap_nxt   = '0;
         end else if (wr_valid && !w_full) begin
            w_wr_en     = 1'b1;
            w_track_nxt = r_track + (ADDR_W+1)'(1);
            w_first_nxt = 1'b1;
            w_gap_nxt   = '0;
            if (r_first_seen && (r_gap >= REST_X) && w_room2) begin
               w_wr_data  = {wr_octave, NOTE_W'(0), REST_LEN};
               w_pend_nxt = {wr_octave, wr_note, wr_length};
               w_busy_nxt = 1'b1;
            end else begin
               w_wr_data  = {wr_octave, wr_note, wr_length};
            end
         end else if (r_gap < REST_X) begin
            w_gap_nxt = r_gap + GAP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_track      <= '0;
         r_first_seen <= 1'b0;
         r_busy       <= 1'b0;
         r_gap        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_track      <= w_track_nxt;
         r_first_seen <= w_first_nxt;
         r_busy       <= w_busy_nxt;
         r_gap        <= w_gap_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_pend <= w_pend_nxt;
      if (w_wr_en)
         r_mem[w_wr_addr] <= w_wr_data;
   end

   // Read-before-write: a same-address collision returns the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rd <= '0;
      else
         r_rd <= r_mem[rd_addr];
   end

   assign rd_octave = r_rd[ENT_W-1 -: OCT_W];
   assign rd_note   = r_rd[LEN_W +: NOTE_W];
   assign rd_length = r_rd[LEN_W-1:0];
   assign track     = r_track;
   assign recording = (r_state == S_REC);
   assign done      = (r_state == S_DONE);
   assign full      = w_full;
   assign busy      = r_busy;

endmodule

// File: tb/tb_record_buffer.sv
// Scoreboard bench for record_buffer: stimulus queues expected status/readback values,
// a negedge monitor pops and compares them.
module tb_record_buffer;

   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          wr_valid = 1'b0;
   logic [2:0]    wr_octave = '0;
   logic [2:0]    wr_note = '0;
   logic [2:0]    wr_length = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [2:0]    rd_octave, rd_note, rd_length;
   logic [AW:0]   track;
   logic          recording, done, full, busy;

   always #5 clk = ~clk;

   record_buffer #(
      .OCT_W(3), .NOTE_W(3), .LEN_W(3), .DEPTH(8), .ADDR_W(AW),
      .REST_CYCLES(20), .GAP_W(5), .REST_LEN(3'd2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
      .wr_valid(wr_valid), .wr_octave(wr_octave), .wr_note(wr_note),
      .wr_length(wr_length), .rd_addr(rd_addr), .rd_octave(rd_octave),
      .rd_note(rd_note), .rd_length(rd_length), .track(track),
      .recording(recording), .done(done), .full(full), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   logic [16:0] q_exp[$];
   logic [16:0] q_mask[$];
   string       q_name[$];
   logic [8:0]  q_rd[$];
   string       q_rdn[$];

   logic rd_req = 1'b0;
   logic rd_vld = 1'b0;
   always @(posedge clk) rd_vld <= rd_req;

   always @(negedge clk) begin : monitor
      logic [16:0] got, e, m;
      logic [8:0]  er;
      string       n;
      got = {rd_octave, rd_note, rd_length, track, recording, done, full, busy};
      if (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         m = q_mask.pop_front();
         n = q_name.pop_front();
         checks++;
         if ((got & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: got %h required %h (rd,track,rec,done,full,busy)", n, got & m, e & m);
         end
      end
      if (rd_vld) begin
         checks++;
         if (q_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h required none", got[16:8]);
         end else begin
            er = q_rd.pop_front();
            n  = q_rdn.pop_front();
            if (got[16:8] !== er) begin
               errors++;
               $display("FAIL %s: got %h required %h", n, got[16:8], er);
            end
         end
      end
   end

   function automatic logic [8:0] pk(input int o, input int n, input int l);
      return {3'(o), 3'(n), 3'(l)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) step();
   endtask

   task automatic exp_st(input string n, input int tr, input logic r, input logic d,
                         input logic f, input logic b);
      q_exp.push_back({9'd0, 4'(tr), r, d, f, b});
      q_mask.push_back(17'h000FF);
      q_name.push_back(n);
   endtask

   task automatic exp_all_zero(input string n);
      q_exp.push_back(17'h0);
      q_mask.push_back(17'h1FFFF);
      q_name.push_back(n);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   task automatic note(input int o, input int n, input int l);
      wr_octave = 3'(o); wr_note = 3'(n); wr_length = 3'(l);
      wr_valid = 1'b1; step(); wr_valid = 1'b0;
   endtask

   task automatic rd_chk(input string n, input int a, input logic [8:0] e);
      rd_addr = AW'(a);
      rd_req  = 1'b1;
      q_rd.push_back(e);
      q_rdn.push_back(n);
      step();
      rd_req  = 1'b0;
   endtask

   initial begin
      idle(2);
      exp_all_zero("reset_state");
      step();
      rst_n = 1'b1;
      en = 1'b1;
      step();
      exp_st("idle_after_reset", 0, 0, 0, 0, 0);

      // Basic take: three notes 10 cycles apart
      pulse_start();             exp_st("basic_start", 0, 1, 0, 0, 0);
      note(4, 1, 1);             exp_st("basic_n1", 1, 1, 0, 0, 0);
      idle(9); note(4, 3, 1);    exp_st("basic_n2", 2, 1, 0, 0, 0);
      idle(9); note(4, 5, 1);    exp_st("basic_n3", 3, 1, 0, 0, 0);
      pulse_stop();              exp_st("basic_stop", 3, 0, 1, 0, 0);
      rd_chk("basic_rd0", 0, pk(4, 1, 1));
      rd_chk("basic_rd1", 1, pk(4, 3, 1));
      rd_chk("basic_rd2", 2, pk(4, 5, 1));

      // Rest insertion and the 19/20 gap boundary
      pulse_start();             exp_st("rest_start", 0, 1, 0, 0, 0);
      idle(30); note(4, 2, 1);   exp_st("rest_first_no_rest", 1, 1, 0, 0, 0);
      idle(25); note(4, 6, 1);   exp_st("rest_busy", 2, 1, 0, 0, 1);
      step();                    exp_st("rest_pending", 3, 1, 0, 0, 0);
      idle(19); note(4, 7, 1);   exp_st("gap19_no_rest", 4, 1, 0, 0, 0);
      idle(20); note(3, 1, 2);   exp_st("gap20_rest", 5, 1, 0, 0, 1);
      note(3, 4, 4);             exp_st("busy_drop", 6, 1, 0, 0, 0);
      rd_chk("rest_rd0", 0, pk(4, 2, 1));
      rd_chk("rest_rd1", 1, pk(4, 0, 2));
      rd_chk("rest_rd2", 2, pk(4, 6, 1));
      rd_chk("rest_rd3", 3, pk(4, 7, 1));
      rd_chk("rest_rd4", 4, pk(3, 0, 2));
      rd_chk("rest_rd5", 5, pk(3, 1, 2));

      // Full boundary: one slot left, long gap, rest skipped
      note(1, 1, 1);             exp_st("full_n7", 7, 1, 0, 0, 0);
      idle(25); note(2, 2, 2);   exp_st("full_no_rest", 8, 1, 0, 1, 0);
      note(5, 5, 5);             exp_st("full_ignore", 8, 1, 0, 1, 0);
      rd_chk("full_rd6", 6, pk(1, 1, 1));
      rd_chk("full_rd7", 7, pk(2, 2, 2));

      // Control precedence
      pulse_stop();              exp_st("stop_full", 8, 0, 1, 1, 0);
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      exp_st("start_wins", 0, 1, 0, 0, 0);
      note(1, 3, 1);             exp_st("sb_n1", 1, 1, 0, 0, 0);
      idle(22); note(1, 5, 3);   exp_st("sb_busy", 2, 1, 0, 0, 1);
      pulse_stop();              exp_st("stop_while_busy", 3, 0, 1, 0, 0);
      rd_chk("sb_rd0", 0, pk(1, 3, 1));
      rd_chk("sb_rd1", 1, pk(1, 0, 2));
      rd_chk("sb_rd2", 2, pk(1, 5, 3));
      note(7, 7, 7);             exp_st("done_ignore_wr", 3, 0, 1, 0, 0);

      // Mode exit with en low
      pulse_start();             exp_st("en_start", 0, 1, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         note(2, k, 1);
         step();
      end
      exp_st("en_track5", 5, 1, 0, 0, 0);
      en = 1'b0; step();         exp_st("en_low_idle", 5, 0, 0, 0, 0);
      pulse_start();             exp_st("en_low_start", 5, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++)
         rd_chk("en_low_rd", k, pk(2, k + 1, 1));

      // Asynchronous reset mid-take
      en = 1'b1;
      pulse_start();             exp_st("rst_start", 0, 1, 0, 0, 0);
      note(2, 1, 1);
      note(2, 2, 1);             exp_st("rst_track2", 2, 1, 0, 0, 0);
      rd_chk("rst_pre_rd", 0, pk(2, 1, 1));
      step();
      rst_n = 1'b0;
      exp_all_zero("async_reset");
      @(negedge clk); #1;
      rst_n = 1'b1;
      step();                    exp_st("post_reset", 0, 0, 0, 0, 0);

      idle(3);
      checks++;
      if (q_exp.size() != 0 || q_rd.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending required 0/0", q_exp.size(), q_rd.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/record_buffer.md
# record_buffer

Captures notes the player performs in free-play and stores them as a replayable user song. It sits beside the song ROM and presents the same indexed read view: a note index in, octave/note/length plus track length out. Playback and scoring logic can consume a recorded take exactly like a built-in song. It is the writer side of the song-data interface that the play and scoring path reads.

## Interface
- OCT_W, 3, octave field width
- NOTE_W, 3, note field width; note code 0 = rest
- LEN_W, 3, length code width
- DEPTH, 64, number of stored entries
- ADDR_W, 6, index width, log2(DEPTH)
- REST_CYCLES, 50_000_000, idle gap that triggers an automatic rest entry (0.5 s at 100 MHz)
- GAP_W, 26, gap counter width; must hold REST_CYCLES
- REST_LEN, 3'd2, length code written for inserted rests

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- en  in  1  record mode selected; low forces IDLE and keeps stored data
- start  in  1  one-cycle pulse: clear take, begin recording
- stop  in  1  one-cycle pulse: end recording
- wr_valid  in  1  one-cycle pulse per completed played note
- wr_octave / wr_note / wr_length  in  OCT_W/NOTE_W/LEN_W  note sampled when wr_valid=1
- rd_addr  in  ADDR_W  playback index
- rd_octave / rd_note / rd_length  out  OCT_W/NOTE_W/LEN_W  entry at rd_addr, registered
- track  out  ADDR_W+1  number of valid entries, 0..DEPTH
- recording  out  1  state==REC
- done  out  1  state==DONE
- full  out  1  track==DEPTH
- busy  out  1  deferred note write pending

## Operation
- States: IDLE, REC, DONE.
  - IDLE: on start & en, go to REC, track←0, first_seen←0.
  - REC: on stop, go to DONE; on start, restart the take (track←0, first_seen←0).
  - DONE: on start, go to REC with a cleared take.
  - en=0 in any state: go to IDLE next edge; pending write is discarded; track and memory are retained.
- start and stop in the same cycle: start wins.
- Note write (REC, wr_valid=1, busy=0):
  - If first_seen=1, gap≥REST_CYCLES, and free slots≥2: write rest {wr_octave, 0, REST_LEN} at index track this cycle. Latch the note into the pending register and set busy; the note is written at track+1 on the next cycle, then busy clears.
  - Otherwise write the note directly at index track.
  - Each write increments track by 1. first_seen←1.
- Only one slot free: the rest is skipped and the note is written.
- full=1: wr_valid is ignored and nothing changes; state stays REC until stop or start.
- wr_valid while busy=1: ignored, entry dropped.
- wr_valid outside REC: ignored.
- Gap counter:
  - Cleared on every note write and on start.
  - Increments each REC cycle and saturates at REST_CYCLES.
  - Frozen outside REC.
- stop while busy: the pending note is still written on that edge, then state becomes DONE.
- Memory: DEPTH × (OCT_W+NOTE_W+LEN_W). One write port; one synchronous read port.

## Timing
- Reset values: state IDLE, track 0, recording 0, done 0, full 0, busy 0, rd_* 0, gap 0, first_seen 0. Memory contents are not reset.
- Read latency: rd_* reflects rd_addr sampled at the previous edge (1 cycle).
- Read/write collision on the same address: rd_* returns old contents.
- rd_addr≥track: returns stale memory; the consumer bounds its index by track.
- track, full, recording and done update on the edge after the causing event.
- Rest insertion costs one extra cycle: busy is high for exactly 1 cycle.
- rst_n low mid-recording: immediate return to reset values. The take is lost (track=0).

## Test plan
- Basic take:
  - Stimulus: start, then 3 wr_valid pulses 10 cycles apart (octave 4, notes 1,3,5, length 1), then stop.
  - Required: track=3, done=1; reading addresses 0..2 returns notes 1,3,5 one cycle after each rd_addr.
- Rest insertion:
  - Stimulus: REST_CYCLES overridden to 20. Note, then a 25-cycle gap, then note 6.
  - Required: entries [note, rest{4,0,2}, 6]; busy high for 1 cycle; track=3.
  - Also: a gap of 19 cycles inserts no rest; the first note after start never inserts a rest.
- Full boundary:
  - Stimulus: DEPTH=4. With 3 entries stored and a long gap, send a note.
  - Required: the note is written without a rest; full=1; track=4.
  - Further wr_valid: no change.
- Control precedence:
  - Stimulus: start+stop in the same cycle while in DONE.
  - Required: state REC, track=0.
  - Stimulus: stop while busy.
  - Required: the pending note is stored, then done=1.
- Mode exit and reset:
  - Stimulus: en low mid-take with track=5.
  - Required: IDLE, track stays 5, readback intact.
  - Stimulus: rst_n pulse mid-take.
  - Required: all outputs 0 asynchronously.
